// File: rtl/riscv_alu_pkg.sv
// Shared types and encodings for the RV64 ALU decode-and-issue stage.
package riscv_alu_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_ctrl_t       ctrl;
        logic            illegal;
    } issue_beat_t;

    // Shared funct3 map for OP/OP_IMM; returns {legal, ctrl}.
    function automatic logic [4:0] f3_to_ctrl(input logic [2:0] f3);
        logic [4:0] r;
        r = {1'b0, ALU_AND};
        case (f3)
            F3_ADD:  r = {1'b1, ALU_ADD};
            F3_SLT:  r = {1'b1, ALU_SLT};
            F3_OR:   r = {1'b1, ALU_OR};
            F3_AND:  r = {1'b1, ALU_AND};
            default: r = {1'b0, ALU_AND};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational I/S immediate generator, sign-extended from instr[31].
module riscv_imm_gen
    import riscv_alu_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic [31:0]      instr,
    output logic [WIDTH-1:0] imm
);

    logic unused_bits;
    assign unused_bits = ^instr[19:12];

    always_comb begin
        imm = {{(WIDTH-12){instr[31]}}, instr[31:20]};
        if (instr[6:0] == OPC_STORE) begin
            imm = {{(WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
        end
    end

endmodule

// File: rtl/riscv_alu_issue.sv
// ID/EX decode-and-issue stage with a registered valid/ready output slot.
// Define RISCV_ALU_ISSUE_SKID_EN to add a one-entry skid register and a registered in_ready.
module riscv_alu_issue
    import riscv_alu_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [3:0]       alu_ctrl,
    output logic             illegal
);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [WIDTH-1:0] imm;
    logic [4:0]       f3_dec;
    logic             legal;
    issue_beat_t      dec;
    issue_beat_t      slot_q;
    logic             accept;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign f3_dec = f3_to_ctrl(funct3);

    riscv_imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
        .instr (instr),
        .imm   (imm)
    );

    // Decode; undecodable words issue as an all-zero beat flagged illegal.
    always_comb begin
        dec         = '0;
        dec.a       = rs1_data;
        dec.b       = rs2_data;
        dec.ctrl    = ALU_AND;
        dec.illegal = 1'b0;
        legal       = 1'b1;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    legal    = f3_dec[4];
                    dec.ctrl = alu_ctrl_t'(f3_dec[3:0]);
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    dec.ctrl = ALU_SUB;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                legal    = f3_dec[4];
                dec.ctrl = alu_ctrl_t'(f3_dec[3:0]);
                dec.b    = imm;
            end
            OPC_LOAD, OPC_STORE: begin
                dec.ctrl = ALU_ADD;
                dec.b    = imm;
            end
            OPC_BRANCH: begin
                legal    = (funct3 == F3_BEQ);
                dec.ctrl = ALU_SUB;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    assign accept = in_valid && in_ready;

`ifdef RISCV_ALU_ISSUE_SKID_EN
    issue_beat_t skid_q;
    logic        skid_full;

    assign in_ready = !skid_full && !flush;

    // Output slot plus skid; skid only fills while the slot is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_full) begin
                slot_q    <= skid_q;
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    slot_q <= dec;
                end
            end
        end else if (accept) begin
            skid_q    <= dec;
            skid_full <= 1'b1;
        end
    end
`else
    assign in_ready = !flush && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q    <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            slot_q    <= dec;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

    assign out_a    = slot_q.a;
    assign out_b    = slot_q.b;
    assign alu_ctrl = slot_q.ctrl;
    assign illegal  = slot_q.illegal;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Randomized bench for riscv_alu_issue against a queue-based reference model.
// Build with RISCV_ALU_ISSUE_SKID_EN to check the skid variant.
module tb_riscv_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_a;
    logic [63:0] out_b;
    logic [3:0]  alu_ctrl;
    logic        illegal;

    int checks = 0;
    int errors = 0;

`ifdef RISCV_ALU_ISSUE_SKID_EN
    localparam int CAPACITY = 2;
`else
    localparam int CAPACITY = 1;
`endif

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  c;
        logic        ill;
    } beat_t;

    beat_t q[$];
    logic  post_reset;

    riscv_alu_issue #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .alu_ctrl  (alu_ctrl),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] sext12(input logic [11:0] v);
        longint s;
        s = longint'(v);
        if (v[11]) s = s - 4096;
        return 64'(s);
    endfunction

    // Reference decode computed directly from the instruction-set rules.
    function automatic beat_t ref_decode(input logic [31:0] w, input logic [63:0] r1, input logic [63:0] r2);
        beat_t       r;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [3:0]  f3code;
        logic        f3ok;
        logic [11:0] simm;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        simm = {w[31:25], w[11:7]};
        f3ok = 1'b1;
        case (f3)
            3'd0: f3code = 4'b0010;
            3'd7: f3code = 4'b0000;
            3'd6: f3code = 4'b0001;
            3'd2: f3code = 4'b0111;
            default: begin f3code = 4'b0000; f3ok = 1'b0; end
        endcase
        r.a = r1; r.b = 64'd0; r.c = 4'b0000; r.ill = 1'b1;
        if (op == 7'h33 && f7 == 7'h00 && f3ok) begin
            r.b = r2; r.c = f3code; r.ill = 1'b0;
        end else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
            r.b = r2; r.c = 4'b0110; r.ill = 1'b0;
        end else if (op == 7'h13 && f3ok) begin
            r.b = sext12(w[31:20]); r.c = f3code; r.ill = 1'b0;
        end else if (op == 7'h03) begin
            r.b = sext12(w[31:20]); r.c = 4'b0010; r.ill = 1'b0;
        end else if (op == 7'h23) begin
            r.b = sext12(simm); r.c = 4'b0010; r.ill = 1'b0;
        end else if (op == 7'h63 && f3 == 3'd0) begin
            r.b = r2; r.c = 4'b0110; r.ill = 1'b0;
        end
        if (r.ill) r.a = 64'd0;
        return r;
    endfunction

    // One clock of stimulus: drive, check against model, then advance model past the edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [63:0] r1,
                         input logic [63:0] r2, input logic ordy, input logic fl, input logic rst);
        logic exp_rdy;
        beat_t h;
        @(negedge clk);
        in_valid = v; instr = ins; rs1_data = r1; rs2_data = r2;
        out_ready = ordy; flush = fl; rst_n = !rst;
        #1;
        exp_rdy = !fl && ((q.size() < CAPACITY) || (CAPACITY == 1 && ordy));
        if (!rst) check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        if (post_reset) begin
            check("rst_out_a", out_a, 64'd0);
            check("rst_out_b", out_b, 64'd0);
            check("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
            check("rst_illegal", {63'd0, illegal}, 64'd0);
            post_reset = 1'b0;
        end
        if (q.size() > 0) begin
            h = q[0];
            check("out_a", out_a, h.a);
            check("out_b", out_b, h.b);
            check("alu_ctrl", {60'd0, alu_ctrl}, {60'd0, h.c});
            check("illegal", {63'd0, illegal}, {63'd0, h.ill});
        end
        if (rst) begin
            q.delete();
            post_reset = 1'b1;
        end else if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (v && exp_rdy) q.push_back(ref_decode(ins, r1, r2));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [2:0]  legal_f3[4];
        legal_f3[0] = 3'd0; legal_f3[1] = 3'd7; legal_f3[2] = 3'd6; legal_f3[3] = 3'd2;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: begin w[6:0] = 7'h33; w[31:25] = 7'h00; w[14:12] = legal_f3[$urandom_range(0, 3)]; end
            1: begin w[6:0] = 7'h33; w[31:25] = 7'h20; w[14:12] = 3'd0; end
            2: w[6:0] = 7'h13;
            3: w[6:0] = 7'h03;
            4: w[6:0] = 7'h23;
            5: begin w[6:0] = 7'h63; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd0; end
            6: begin w[6:0] = 7'h33; if ($urandom_range(0, 1) == 1) w[31:25] = 7'h20; end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'd0; rs1_data = 64'd0; rs2_data = 64'd0;
        post_reset = 1'b1;
        repeat (2) @(posedge clk);

        // ADD x3,x1,x2 with 1-cycle latency, then explicit field checks.
        cycle(1'b1, 32'h002081B3, 64'd5, 64'd7, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        check("add_ctrl", {60'd0, alu_ctrl}, 64'h2);
        check("add_a", out_a, 64'd5);
        check("add_b", out_b, 64'd7);
        cycle(1'b0, 32'h0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);

        // SUB then ADDI -1 back-to-back, SW, FENCE.
        cycle(1'b1, 32'h402081B3, 64'd9, 64'd4, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFF00093, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        check("sub_ctrl", {60'd0, alu_ctrl}, 64'h6);
        cycle(1'b1, 32'h0020A423, 64'h100, 64'd3, 1'b1, 1'b0, 1'b0);
        check("addi_b", out_b, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(1'b1, 32'h0000000F, 64'd1, 64'd2, 1'b1, 1'b0, 1'b0);
        check("sw_b", out_b, 64'd8);
        cycle(1'b0, 32'h0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        check("fence_illegal", {63'd0, illegal}, 64'd1);

        // Backpressure: stream while out_ready is low for 3 cycles.
        for (int i = 0; i < 6; i++)
            cycle(1'b1, rand_instr(), 64'($urandom), 64'($urandom), (i >= 3), 1'b0, 1'b0);
        // Flush with a valid output and a valid input.
        cycle(1'b1, 32'h002081B3, 64'd1, 64'd1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h002081B3, 64'd2, 64'd2, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h002081B3, 64'd3, 64'd3, 1'b1, 1'b0, 1'b0);
        // Reset mid-stream, then first beat after release.
        cycle(1'b1, 32'h402081B3, 64'd4, 64'd4, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h402081B3, 64'd5, 64'd5, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h002081B3, 64'd6, 64'd6, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 3) != 0), rand_instr(), {$urandom, $urandom},
                  {$urandom, $urandom}, ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 40) == 0), ($urandom_range(0, 150) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
